// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle MIPS controller.
package mc_pkg;

    // FSM state encoding; codes 14 and 15 are unused and recover to S_FETCH.
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BREX    = 4'd8,
        S_IMMEX   = 4'd9,
        S_IMMWB   = 4'd10,
        S_JEX     = 4'd11,
        S_JALEX   = 4'd12,
        S_JREX    = 4'd13
    } statetype_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FUNCT_JR = 6'b001000;

    localparam logic [2:0] ALUOP_ADD   = 3'b000;
    localparam logic [2:0] ALUOP_SUB   = 3'b001;
    localparam logic [2:0] ALUOP_FUNCT = 3'b010;
    localparam logic [2:0] ALUOP_AND   = 3'b011;
    localparam logic [2:0] ALUOP_OR    = 3'b100;

    // Complete datapath control word, first field is the MSB.
    typedef struct packed {
        logic       mem_req;
        logic       iord;
        logic       memwrite;
        logic       irwrite;
        logic       pcwrite;
        logic [1:0] pcsrc;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       immzero;
        logic [2:0] aluop;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       link;
        logic       half;
        logic       b;
        logic       lbu;
        logic       illegal_op;
    } ctrl_t;

    // True for every opcode the controller knows how to sequence.
    function automatic logic op_legal(logic [5:0] op);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_LBU, OP_LH, OP_BEQ, OP_BNE,
            OP_ADDI, OP_ANDI, OP_ORI, OP_J, OP_JAL: op_legal = 1'b1;
            default:                                op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mc_outdec.sv
// Moore output decoder: state (plus op, mem_ready, zero where needed) to control word.
module mc_outdec
    import mc_pkg::*;
(
    input  statetype_t  state,
    input  logic [5:0]  op,
    input  logic        mem_ready,
    input  logic        zero,
    output ctrl_t       ctrl
);

    // Per-state control word; everything not named in a state stays 0.
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req = 1'b1;
                ctrl.alusrcb = 2'b01;
                ctrl.aluop   = ALUOP_ADD;
                ctrl.irwrite = mem_ready;
                ctrl.pcwrite = mem_ready;
            end
            S_DECODE: begin
                ctrl.alusrcb    = 2'b11;
                ctrl.aluop      = ALUOP_ADD;
                ctrl.illegal_op = !op_legal(op);
            end
            S_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b10;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl.mem_req = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_MEMWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
                ctrl.b        = (op == OP_LBU);
                ctrl.lbu      = (op == OP_LBU);
                ctrl.half     = (op == OP_LH);
            end
            S_MEMWR: begin
                ctrl.mem_req  = 1'b1;
                ctrl.iord     = 1'b1;
                ctrl.memwrite = mem_ready;
            end
            S_RTYPEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_RTYPEWB: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
            end
            S_BREX: begin
                // Branch taken when zero disagrees with the bne sense.
                ctrl.alusrca = 1'b1;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.pcsrc   = 2'b01;
                ctrl.pcwrite = zero ^ (op == OP_BNE);
            end
            S_IMMEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = 2'b10;
                ctrl.immzero = (op == OP_ANDI) || (op == OP_ORI);
                if (op == OP_ANDI)     ctrl.aluop = ALUOP_AND;
                else if (op == OP_ORI) ctrl.aluop = ALUOP_OR;
                else                   ctrl.aluop = ALUOP_ADD;
            end
            S_IMMWB: begin
                ctrl.regwrite = 1'b1;
            end
            S_JEX: begin
                ctrl.pcsrc   = 2'b10;
                ctrl.pcwrite = 1'b1;
            end
            S_JALEX: begin
                ctrl.pcsrc    = 2'b10;
                ctrl.pcwrite  = 1'b1;
                ctrl.regwrite = 1'b1;
                ctrl.link     = 1'b1;
            end
            S_JREX: begin
                ctrl.pcsrc   = 2'b11;
                ctrl.pcwrite = 1'b1;
            end
            default: ctrl = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS controller: state register, next-state logic and output decode.
//
// Memory handshake: mem_req is a request (valid) held high for the whole of
// S_FETCH, S_MEMRD and S_MEMWR; the access completes in the cycle mem_ready
// (ready) is 1, and only then does the FSM leave the state. irwrite, pcwrite
// and memwrite are qualified by mem_ready so they fire exactly once.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter statetype_t RESET_STATE = S_FETCH
)
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       pcwrite,
    output logic [1:0] pcsrc,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       immzero,
    output logic [2:0] aluop,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       link,
    output logic       half,
    output logic       b,
    output logic       lbu,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    statetype_t state_q, state_d;
    ctrl_t      ctrl_raw;
    ctrl_t      ctrl_out;

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= RESET_STATE;
        else        state_q <= state_d;
    end

    // Next-state logic; memory states wait for mem_ready.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW, OP_LBU, OP_LH: state_d = S_MEMADR;
                    OP_RTYPE: state_d = (funct == FUNCT_JR) ? S_JREX : S_RTYPEEX;
                    OP_BEQ, OP_BNE:              state_d = S_BREX;
                    OP_ADDI, OP_ANDI, OP_ORI:    state_d = S_IMMEX;
                    OP_J:                        state_d = S_JEX;
                    OP_JAL:                      state_d = S_JALEX;
                    default:                     state_d = S_FETCH;
                endcase
            end
            S_MEMADR:  state_d = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:   state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_RTYPEEX: state_d = S_RTYPEWB;
            S_IMMEX:   state_d = S_IMMWB;
            default:   state_d = S_FETCH;
        endcase
    end

    mc_outdec u_outdec (
        .state     (state_q),
        .op        (op),
        .mem_ready (mem_ready),
        .zero      (zero),
        .ctrl      (ctrl_raw)
    );

    // Hold every output low while reset is asserted, aborting any access in flight.
    always_comb begin
        ctrl_out = '0;
        if (reset) ctrl_out = ctrl_raw;
    end

    assign mem_req    = ctrl_out.mem_req;
    assign iord       = ctrl_out.iord;
    assign memwrite   = ctrl_out.memwrite;
    assign irwrite    = ctrl_out.irwrite;
    assign pcwrite    = ctrl_out.pcwrite;
    assign pcsrc      = ctrl_out.pcsrc;
    assign alusrca    = ctrl_out.alusrca;
    assign alusrcb    = ctrl_out.alusrcb;
    assign immzero    = ctrl_out.immzero;
    assign aluop      = ctrl_out.aluop;
    assign regwrite   = ctrl_out.regwrite;
    assign regdst     = ctrl_out.regdst;
    assign memtoreg   = ctrl_out.memtoreg;
    assign link       = ctrl_out.link;
    assign half       = ctrl_out.half;
    assign b          = ctrl_out.b;
    assign lbu        = ctrl_out.lbu;
    assign illegal_op = ctrl_out.illegal_op;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: instruction-level expected traces, CPI table, reset abort.
module tb_multicycle_controller;
    import mc_pkg::*;

    localparam int W = 4 + $bits(ctrl_t);

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = '0;
    logic [5:0] funct = '0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b0;
    logic       mem_req, iord, memwrite, irwrite, pcwrite;
    logic [1:0] pcsrc, alusrcb;
    logic       alusrca, immzero;
    logic [2:0] aluop;
    logic       regwrite, regdst, memtoreg, link, half, b, lbu, illegal_op;
    logic [3:0] state_dbg;
    ctrl_t      act_c;

    int checks = 0;
    int failures = 0;

    logic           mr_q[$];
    logic [W-1:0]   exp_q[$];

    logic mon_en = 1'b0;
    logic mw_seen = 1'b0;

    typedef struct {
        string      name;
        logic [5:0] op;
        logic [5:0] funct;
        logic       z;
        int         fw;
        int         mw;
        int         cyc;
    } vec_t;

    vec_t vecs[16];
    logic [5:0] op_pool[14];

    multicycle_controller dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .iord(iord),
        .memwrite(memwrite), .irwrite(irwrite), .pcwrite(pcwrite),
        .pcsrc(pcsrc), .alusrca(alusrca), .alusrcb(alusrcb),
        .immzero(immzero), .aluop(aluop), .regwrite(regwrite),
        .regdst(regdst), .memtoreg(memtoreg), .link(link), .half(half),
        .b(b), .lbu(lbu), .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    // Clock
    always #5 clk = ~clk;

    assign act_c = {mem_req, iord, memwrite, irwrite, pcwrite, pcsrc, alusrca,
                    alusrcb, immzero, aluop, regwrite, regdst, memtoreg, link,
                    half, b, lbu, illegal_op};

    // Watch for any memory write while the reset-abort sequence runs.
    always @(posedge clk) begin
        if (mon_en && memwrite === 1'b1) mw_seen = 1'b1;
    end

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(logic mr, statetype_t s, ctrl_t c);
        mr_q.push_back(mr);
        exp_q.push_back({s, c});
    endtask

    function automatic ctrl_t fetch_c(logic mr);
        ctrl_t c = '0;
        c.mem_req = 1'b1;
        c.alusrcb = 2'b01;
        c.aluop   = ALUOP_ADD;
        c.irwrite = mr;
        c.pcwrite = mr;
        return c;
    endfunction

    // Driver + scoreboard: apply queued mem_ready, compare state and outputs each cycle.
    task automatic drain(string name);
        logic [W-1:0] e;
        while (exp_q.size() > 0) begin
            mem_ready = mr_q.pop_front();
            e = exp_q.pop_front();
            @(negedge clk);
            check(name, 32'({state_dbg, act_c}), 32'(e));
            @(posedge clk);
            #1;
        end
    endtask

    // Reference model: expected cycle trace of one instruction from its class.
    task automatic run_instr(string name, logic [5:0] o, logic [5:0] f, logic z, int fw, int mw);
        ctrl_t c;
        logic  mr;
        op = o; funct = f; zero = z;
        for (int i = 0; i <= fw; i++) begin
            mr = (i == fw);
            push(mr, S_FETCH, fetch_c(mr));
        end
        c = '0; c.alusrcb = 2'b11; c.aluop = ALUOP_ADD;
        c.illegal_op = !(o inside {OP_RTYPE, OP_LW, OP_SW, OP_LBU, OP_LH, OP_BEQ,
                                   OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_J, OP_JAL});
        push(1'($urandom_range(0, 1)), S_DECODE, c);
        if (o inside {OP_LW, OP_SW, OP_LBU, OP_LH}) begin
            c = '0; c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluop = ALUOP_ADD;
            push(1'($urandom_range(0, 1)), S_MEMADR, c);
            for (int i = 0; i <= mw; i++) begin
                mr = (i == mw);
                c = '0; c.mem_req = 1'b1; c.iord = 1'b1;
                if (o == OP_SW) begin
                    c.memwrite = mr;
                    push(mr, S_MEMWR, c);
                end else begin
                    push(mr, S_MEMRD, c);
                end
            end
            if (o != OP_SW) begin
                c = '0; c.regwrite = 1'b1; c.memtoreg = 1'b1;
                c.b = (o == OP_LBU); c.lbu = (o == OP_LBU); c.half = (o == OP_LH);
                push(1'($urandom_range(0, 1)), S_MEMWB, c);
            end
        end else if (o == OP_RTYPE && f == FUNCT_JR) begin
            c = '0; c.pcsrc = 2'b11; c.pcwrite = 1'b1;
            push(1'($urandom_range(0, 1)), S_JREX, c);
        end else if (o == OP_RTYPE) begin
            c = '0; c.alusrca = 1'b1; c.aluop = ALUOP_FUNCT;
            push(1'($urandom_range(0, 1)), S_RTYPEEX, c);
            c = '0; c.regwrite = 1'b1; c.regdst = 1'b1;
            push(1'($urandom_range(0, 1)), S_RTYPEWB, c);
        end else if (o == OP_BEQ || o == OP_BNE) begin
            c = '0; c.alusrca = 1'b1; c.aluop = ALUOP_SUB; c.pcsrc = 2'b01;
            c.pcwrite = (o == OP_BEQ) ? z : !z;
            push(1'($urandom_range(0, 1)), S_BREX, c);
        end else if (o inside {OP_ADDI, OP_ANDI, OP_ORI}) begin
            c = '0; c.alusrca = 1'b1; c.alusrcb = 2'b10;
            c.immzero = (o != OP_ADDI);
            c.aluop = (o == OP_ANDI) ? ALUOP_AND : (o == OP_ORI) ? ALUOP_OR : ALUOP_ADD;
            push(1'($urandom_range(0, 1)), S_IMMEX, c);
            c = '0; c.regwrite = 1'b1;
            push(1'($urandom_range(0, 1)), S_IMMWB, c);
        end else if (o == OP_J || o == OP_JAL) begin
            c = '0; c.pcsrc = 2'b10; c.pcwrite = 1'b1;
            c.regwrite = (o == OP_JAL); c.link = (o == OP_JAL);
            push(1'($urandom_range(0, 1)), (o == OP_J) ? S_JEX : S_JALEX, c);
        end
        drain(name);
    endtask

    // Count cycles from FETCH back to FETCH, answering memory with fixed wait counts.
    task automatic measure(logic [5:0] o, logic [5:0] f, logic z, int fw, int mw, output int n);
        int   fc;
        int   mc;
        logic left;
        fc = fw; mc = mw; left = 1'b0; n = 0;
        op = o; funct = f; zero = z;
        for (int i = 0; i < 40; i++) begin
            if (state_dbg == S_FETCH) begin
                mem_ready = (fc == 0);
                if (fc > 0) fc--;
            end else if (state_dbg == S_MEMRD || state_dbg == S_MEMWR) begin
                mem_ready = (mc == 0);
                if (mc > 0) mc--;
            end else begin
                mem_ready = 1'b1;
            end
            n++;
            @(posedge clk);
            #1;
            if (state_dbg != S_FETCH) left = 1'b1;
            if (left && state_dbg == S_FETCH) break;
        end
    endtask

    initial begin
        ctrl_t zc;
        ctrl_t c;
        int    n;
        zc = '0;

        vecs[0]  = '{"lw",        OP_LW,    6'h00,    1'b0, 0, 0, 5};
        vecs[1]  = '{"lw_wait",   OP_LW,    6'h00,    1'b0, 2, 2, 9};
        vecs[2]  = '{"sw",        OP_SW,    6'h00,    1'b0, 0, 0, 4};
        vecs[3]  = '{"sw_wait",   OP_SW,    6'h00,    1'b0, 1, 3, 8};
        vecs[4]  = '{"lbu",       OP_LBU,   6'h00,    1'b0, 0, 1, 6};
        vecs[5]  = '{"lh",        OP_LH,    6'h00,    1'b0, 0, 0, 5};
        vecs[6]  = '{"rtype_add", OP_RTYPE, 6'h20,    1'b0, 0, 0, 4};
        vecs[7]  = '{"jr",        OP_RTYPE, FUNCT_JR, 1'b0, 0, 0, 3};
        vecs[8]  = '{"beq_z1",    OP_BEQ,   6'h00,    1'b1, 0, 0, 3};
        vecs[9]  = '{"bne_z1",    OP_BNE,   6'h00,    1'b1, 0, 0, 3};
        vecs[10] = '{"addi",      OP_ADDI,  6'h00,    1'b0, 1, 0, 5};
        vecs[11] = '{"andi",      OP_ANDI,  6'h00,    1'b0, 0, 0, 4};
        vecs[12] = '{"ori",       OP_ORI,   6'h00,    1'b0, 0, 0, 4};
        vecs[13] = '{"j",         OP_J,     6'h00,    1'b0, 0, 0, 3};
        vecs[14] = '{"jal",       OP_JAL,   6'h00,    1'b0, 0, 0, 3};
        vecs[15] = '{"illegal",   6'h3f,    6'h00,    1'b0, 0, 0, 2};

        op_pool = '{OP_RTYPE, OP_LW, OP_SW, OP_LBU, OP_LH, OP_BEQ, OP_BNE,
                    OP_ADDI, OP_ANDI, OP_ORI, OP_J, OP_JAL, 6'h3f, 6'h3e};

        // Reset: all outputs low, state FETCH, even with mem_ready high.
        reset = 1'b0; mem_ready = 1'b1; op = OP_LW;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_state", 32'({state_dbg, act_c}), 32'({S_FETCH, zc}));
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Table: per-cycle trace, then DUT-measured cycle count.
        for (int i = 0; i < 16; i++) begin
            run_instr(vecs[i].name, vecs[i].op, vecs[i].funct, vecs[i].z, vecs[i].fw, vecs[i].mw);
            measure(vecs[i].op, vecs[i].funct, vecs[i].z, vecs[i].fw, vecs[i].mw, n);
            check({vecs[i].name, "_cycles"}, 32'(n), 32'(vecs[i].cyc));
        end

        // sw aborted by reset in MEMWR while the memory stalls.
        op = OP_SW; funct = '0; zero = 1'b0;
        mon_en = 1'b1; mw_seen = 1'b0;
        push(1'b1, S_FETCH, fetch_c(1'b1));
        c = '0; c.alusrcb = 2'b11; c.aluop = ALUOP_ADD;
        push(1'b1, S_DECODE, c);
        c = '0; c.alusrca = 1'b1; c.alusrcb = 2'b10; c.aluop = ALUOP_ADD;
        push(1'b1, S_MEMADR, c);
        c = '0; c.mem_req = 1'b1; c.iord = 1'b1;
        push(1'b0, S_MEMWR, c);
        drain("sw_rst_pre");
        mem_ready = 1'b0; reset = 1'b0;
        @(negedge clk);
        check("sw_rst_memwr", 32'({state_dbg, act_c}), 32'({S_MEMWR, zc}));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("sw_rst_fetch", 32'({state_dbg, act_c}), 32'({S_FETCH, zc}));
        @(posedge clk);
        #1;
        reset = 1'b1; mem_ready = 1'b0;
        @(negedge clk);
        check("sw_rst_release", 32'({state_dbg, act_c}), 32'({S_FETCH, fetch_c(1'b0)}));
        @(posedge clk);
        #1;
        mon_en = 1'b0;
        check("sw_rst_no_memwrite", 32'(mw_seen), 32'(0));

        // Randomized instruction stream with random wait states.
        for (int k = 0; k < 150; k++) begin
            logic [5:0] ro;
            logic [5:0] rf;
            ro = op_pool[$urandom_range(0, 13)];
            rf = ($urandom_range(0, 2) == 0) ? FUNCT_JR : 6'($urandom_range(0, 63));
            run_instr("rand", ro, rf, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $urandom_range(0, 3));
        end
        @(negedge clk);
        check("final_fetch", 32'(state_dbg), 32'(S_FETCH));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore FSM that sequences the shared-memory multicycle MIPS datapath: one memory port for both instruction fetch and data access, and one ALU reused for PC+4, branch target, address and execute.
- Replaces the single-cycle main decoder.
- Issues per-state datapath enables and an aluop code. An external aludec turns aluop into alucontrol.
- Stalls on a memory ready handshake. Supports R-type, jr, lw, lbu, lh, sw, beq, bne, addi, andi, ori, j, jal.

Parameters:
- RESET_STATE, S_FETCH, initial FSM state after reset.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- op  in  6  opcode from instruction register; valid from DECODE onward
- funct  in  6  funct field from instruction register
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access completes this cycle
- mem_req  out  1  memory access request
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  memory write
- irwrite  out  1  instruction register load
- pcwrite  out  1  PC load (already qualified by branch outcome)
- pcsrc  out  2  next PC: 00 ALU result, 01 ALUOut, 10 jump target, 11 rs (jr)
- alusrca  out  1  ALU A: 0 = PC, 1 = rs
- alusrcb  out  2  ALU B: 00 rt, 01 constant 4, 10 immediate, 11 immediate<<2
- immzero  out  1  immediate is zero-extended (andi/ori)
- aluop  out  3  to aludec
- regwrite  out  1  register file write
- regdst  out  1  write register: 1 = rd, 0 = rt
- memtoreg  out  1  write data from memory data register
- link  out  1  write PC to $31
- half  out  1  halfword load
- b  out  1  byte load
- lbu  out  1  unsigned byte load
- illegal_op  out  1  one-cycle pulse on an undefined opcode

Behaviour:
- Reset:
  - When reset==0 at a clk edge, the state becomes S_FETCH.
  - While reset==0, every output is forced to 0.
  - Reset in any state, including mid-MEMWR, aborts the access with no further memwrite.
- States use a 4-bit encoding. Outputs are a pure function of state, plus mem_ready/zero where stated below.
- Memory handshake:
  - mem_req is held high in S_FETCH, S_MEMRD and S_MEMWR until mem_ready=1.
  - The FSM stays in the state while mem_ready=0.
  - Zero wait states gives one cycle per memory state.
- S_FETCH: iord=0, alusrca=0, alusrcb=01, aluop=ADD, pcsrc=00, irwrite=pcwrite=mem_ready. Next state is S_DECODE on mem_ready.
- S_DECODE: alusrca=0, alusrcb=11, aluop=ADD. Next state by op:
  - lw, sw, lbu, lh -> S_MEMADR
  - R-type with funct=001000 -> S_JREX
  - other R-type -> S_RTYPEEX
  - beq, bne -> S_BREX
  - addi, andi, ori -> S_IMMEX
  - j -> S_JEX
  - jal -> S_JALEX
  - anything else -> S_FETCH with illegal_op=1
- S_MEMADR: alusrca=1, alusrcb=10, aluop=ADD. Next state is S_MEMWR for sw, else S_MEMRD.
- S_MEMRD: iord=1. Next state is S_MEMWB on mem_ready.
- S_MEMWB: regwrite=1, regdst=0, memtoreg=1. lbu/b/half from op: lbu gives b=1 and lbu=1; lh gives half=1. Next state S_FETCH.
- S_MEMWR: iord=1, memwrite=mem_ready. Next state is S_FETCH on mem_ready.
- S_RTYPEEX: alusrca=1, alusrcb=00, aluop=FUNCT. Next state S_RTYPEWB.
- S_RTYPEWB: regwrite=1, regdst=1. Next state S_FETCH.
- S_BREX: alusrca=1, alusrcb=00, aluop=SUB, pcsrc=01.
  - ne = (op==bne).
  - pcwrite = zero XOR ne.
  - Next state S_FETCH.
- S_IMMEX: alusrca=1, alusrcb=10. immzero=1 for andi/ori. aluop is ADD, AND or OR. Next state S_IMMWB.
- S_IMMWB: regwrite=1, regdst=0. Next state S_FETCH.
- S_JEX: pcsrc=10, pcwrite=1. Next state S_FETCH.
- S_JALEX: pcsrc=10, pcwrite=1, regwrite=1, link=1. The PC already holds PC+4 from fetch. Next state S_FETCH.
- S_JREX: pcsrc=11, pcwrite=1. Next state S_FETCH.
- Unused state encodings return to S_FETCH on the next edge with all outputs 0.
- CPI with zero wait states:
  - lw = 5, sw = 4
  - R-type / imm = 4
  - branch / j / jal / jr = 3

Decomposition:
- Package mc_pkg holds:
  - state enum statetype_t (4 bit)
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_LBU, OP_LH, OP_BEQ, OP_BNE, OP_ADDI, OP_ANDI, OP_ORI, OP_J, OP_JAL
  - FUNCT_JR
  - aluop constants ALUOP_ADD=000, ALUOP_SUB=001, ALUOP_FUNCT=010, ALUOP_AND=011, ALUOP_OR=100
- Module structure: a state register plus a next-state always_comb.
- Sub-module mc_outdec: state + op -> output vector, purely combinational.

Test Plan:
- lw, mem_ready held 0 for 2 cycles in FETCH and in MEMRD -> sequence FETCH×3, DECODE, MEMADR, MEMRD×3, MEMWB. regwrite=1 and memtoreg=1 in MEMWB only; 9 cycles total.
- beq with zero=1, then bne with zero=1 -> pcwrite=1 with pcsrc=01 in the beq BREX cycle; pcwrite=0 in the bne BREX cycle.
- jal -> DECODE then JALEX with pcwrite=1, regwrite=1, link=1, pcsrc=10; FETCH on the next cycle.
- R-type funct=001000 (jr) -> JREX with pcsrc=11, pcwrite=1, regwrite=0.
- sw: reset driven 0 during MEMWR with mem_ready=0 -> next cycle in FETCH; memwrite never pulses; all outputs 0 while reset=0.
- op=111111 -> illegal_op=1 for exactly one cycle in DECODE, then FETCH; no regwrite or memwrite.
